// File: rtl/mips_pkg.sv
// Shared fetch-stage types: FSM state encoding, buffer entry layout and default addresses.
package mips_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0000_0180;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FULL   = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry fetch buffer with push, pop, flush and an occupancy count (0..2).
module fetch_fifo
    import mips_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_entry,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t slots [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic         do_push;
    logic         do_pop;

    // Requests that would underflow or overflow are dropped rather than corrupting the pointers.
    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage carries no reset; validity comes solely from count.
    always_ff @(posedge clk) begin
        if (do_push && !reset && !flush) begin
            slots[wr_ptr] <= push_entry;
        end
    end

    assign head = slots[rd_ptr];

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch stage: PC register, RUN/FULL/HALTED FSM and a 2-entry buffer toward decode.
// Optional build macro FETCH_ALIGN_CHK_EN turns misaligned redirects into a jump to EXC_VECTOR.
module fetch_controller
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
    input  logic         clk,
    input  logic         reset,
    output logic [31:0]  imem_addr,
    input  logic [31:0]  imem_data,
    input  logic         redirect_valid,
    input  logic [31:0]  redirect_pc,
    input  logic         halt,
    output logic         if_valid,
    input  logic         id_ready,
    output logic [31:0]  if_instr,
    output logic [31:0]  if_pc,
    output logic [31:0]  if_pc_plus4,
`ifdef FETCH_ALIGN_CHK_EN
    output logic         misalign_err,
`endif
    output fetch_state_t fsm_state
);

    fetch_state_t state;
    fetch_state_t state_next;
    logic [31:0]  pc;
    logic [31:0]  pc_next;
    logic [31:0]  redirect_target;
    logic [1:0]   count;
    fetch_entry_t head;
    fetch_entry_t push_entry;
    logic         head_valid;
    logic         pop;
    logic         push;

    assign head_valid = (count != 2'd0);
    // A pop that coincides with a redirect is discarded along with the rest of the buffer.
    assign pop = head_valid && id_ready && !redirect_valid;

`ifdef FETCH_ALIGN_CHK_EN
    logic misaligned;
    logic misalign_flag;

    assign misaligned      = (redirect_pc[1:0] != 2'b00);
    assign redirect_target = misaligned ? EXC_VECTOR : redirect_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_flag <= 1'b0;
        end else if (redirect_valid && misaligned) begin
            misalign_flag <= 1'b1;
        end
    end

    assign misalign_err = misalign_flag && !reset;
`else
    assign redirect_target = redirect_pc & ~32'h0000_0003;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: redirect beats halt, halt beats normal flow control.
    always_comb begin
        state_next = state;
        if (redirect_valid) begin
            state_next = RUN;
        end else if (halt || (state == HALTED)) begin
            state_next = HALTED;
        end else begin
            case (state)
                RUN: begin
                    if (!pop && ((count + {1'b0, push}) == 2'd2)) begin
                        state_next = FULL;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_next = RUN;
                    end
                end
                default: state_next = RUN;
            endcase
        end
    end

    // Output / datapath control: FULL only exists with two entries, so it pushes only alongside a pop.
    always_comb begin
        push    = 1'b0;
        pc_next = pc;
        if (redirect_valid) begin
            pc_next = redirect_target;
        end else if (!halt && (state != HALTED)) begin
            if ((count != 2'd2) || pop) begin
                push    = 1'b1;
                pc_next = pc_plus4(pc);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

    assign push_entry.pc    = pc;
    assign push_entry.instr = imem_data;

    fetch_fifo u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push && !reset),
        .pop        (pop && !reset),
        .flush      (redirect_valid),
        .push_entry (push_entry),
        .head       (head),
        .count      (count)
    );

    assign imem_addr   = pc;
    assign if_valid    = head_valid && !reset;
    assign if_instr    = if_valid ? head.instr : 32'h0;
    assign if_pc       = if_valid ? head.pc : 32'h0;
    assign if_pc_plus4 = if_valid ? pc_plus4(head.pc) : 32'h0;
    assign fsm_state   = state;

endmodule
